// File: rtl/mcycle_ctrl_if.sv
// Bus between the multi-cycle MIPS controller and its datapath.
// Handshake: Op/Funct are held stable by the datapath from DT until the
// instruction's last state; MemReady=1 completes a MEM access in that cycle,
// MemReady=0 keeps the controller in MEM with its MEM strobes held.
interface mcycle_ctrl_if;
  logic [5:0]  Op;
  logic [5:0]  Funct;
  logic        Equal;
  logic        MemReady;
  logic        PCWrite;
  logic        IRWrite;
  logic        RegWrite;
  logic        MemWrite;
  logic [1:0]  NPCSel;
  logic        RegDst;
  logic        ALUsrc;
  logic        MemtoReg;
  logic        JAL;
  logic        JR;
  logic        JALR;
  logic [1:0]  ExtOp;
  logic [3:0]  ALUOp;
  logic [2:0]  State;
  logic [31:0] InstrCnt;
  logic        Illegal;

  // Controller side
  modport slave (
    input  Op, Funct, Equal, MemReady,
    output PCWrite, IRWrite, RegWrite, MemWrite, NPCSel, RegDst, ALUsrc,
           MemtoReg, JAL, JR, JALR, ExtOp, ALUOp, State, InstrCnt, Illegal
  );

  // Datapath side
  modport master (
    output Op, Funct, Equal, MemReady,
    input  PCWrite, IRWrite, RegWrite, MemWrite, NPCSel, RegDst, ALUsrc,
           MemtoReg, JAL, JR, JALR, ExtOp, ALUOp, State, InstrCnt, Illegal
  );
endinterface

// File: rtl/mcycle_ctrl.sv
// Multi-cycle MIPS control unit: IF/DT/EX/MEM/WB FSM, combinational decode
// of selects from Op/Funct, state-qualified strobes, retired-instruction count.
module mcycle_ctrl (
  input  logic         Clk,
  input  logic         Reset,
  mcycle_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_DT  = 3'd1,
    S_EX  = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_t;

  typedef enum logic [3:0] {
    I_ADDU, I_SUBU, I_SLL, I_JR, I_JALR, I_ORI, I_LUI,
    I_LW, I_SW, I_BEQ, I_J, I_JAL, I_BAD
  } instr_t;

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_instr_cnt;
  instr_t      w_instr;
  logic        w_alu;
  logic        w_retire;
  logic [1:0]  w_npc_sel;
  logic        w_reg_dst, w_alu_src, w_mem_to_reg, w_jal, w_jr, w_jalr;
  logic [1:0]  w_ext_op;
  logic [3:0]  w_alu_op;
  logic        w_pc_write, w_ir_write, w_reg_write, w_mem_write, w_illegal;

  // Classify the opcode/funct pair into one instruction kind
  always_comb begin
    w_instr = I_BAD;
    case (bus.Op)
      6'b000000: begin
        case (bus.Funct)
          6'b100001: w_instr = I_ADDU;
          6'b100011: w_instr = I_SUBU;
          6'b000000: w_instr = I_SLL;
          6'b001000: w_instr = I_JR;
          6'b001001: w_instr = I_JALR;
          default:   w_instr = I_BAD;
        endcase
      end
      6'b001101: w_instr = I_ORI;
      6'b001111: w_instr = I_LUI;
      6'b100011: w_instr = I_LW;
      6'b101011: w_instr = I_SW;
      6'b000100: w_instr = I_BEQ;
      6'b000010: w_instr = I_J;
      6'b000011: w_instr = I_JAL;
      default:   w_instr = I_BAD;
    endcase
  end

  assign w_alu = (w_instr == I_ADDU) || (w_instr == I_SUBU) || (w_instr == I_SLL) ||
                 (w_instr == I_ORI)  || (w_instr == I_LUI);

  // Datapath selects depend only on the instruction, so they stay constant
  // for as long as Op/Funct are held
  always_comb begin
    w_npc_sel    = 2'd0;
    w_reg_dst    = 1'b0;
    w_alu_src    = 1'b0;
    w_mem_to_reg = 1'b0;
    w_jal        = 1'b0;
    w_jr         = 1'b0;
    w_jalr       = 1'b0;
    w_ext_op     = 2'd0;
    w_alu_op     = 4'd0;
    case (w_instr)
      I_ADDU: w_reg_dst = 1'b1;
      I_SUBU: begin w_reg_dst = 1'b1; w_alu_op = 4'd1; end
      I_SLL:  begin w_reg_dst = 1'b1; w_alu_op = 4'd4; end
      I_JR:   begin w_npc_sel = 2'd3; w_jr = 1'b1; end
      I_JALR: begin w_npc_sel = 2'd3; w_jalr = 1'b1; w_reg_dst = 1'b1; end
      I_ORI:  begin w_alu_src = 1'b1; w_alu_op = 4'd2; end
      I_LUI:  begin w_alu_src = 1'b1; w_ext_op = 2'd2; w_alu_op = 4'd3; end
      I_LW:   begin w_ext_op = 2'd1; w_alu_src = 1'b1; w_mem_to_reg = 1'b1; end
      I_SW:   begin w_ext_op = 2'd1; w_alu_src = 1'b1; end
      I_BEQ:  begin w_ext_op = 2'd1; w_alu_op = 4'd1; w_npc_sel = 2'd1; end
      I_J:    w_npc_sel = 2'd2;
      I_JAL:  begin w_npc_sel = 2'd2; w_jal = 1'b1; end
      default: ;
    endcase
  end

  // Per-state strobes; everything is silenced while Reset is high
  always_comb begin
    w_pc_write  = 1'b0;
    w_ir_write  = 1'b0;
    w_reg_write = 1'b0;
    w_mem_write = 1'b0;
    w_illegal   = 1'b0;
    if (!Reset) begin
      case (r_state)
        S_IF: begin
          w_ir_write = 1'b1;
          w_pc_write = 1'b1;
        end
        S_DT: begin
          w_pc_write  = (w_instr == I_J) || (w_instr == I_JAL);
          w_reg_write = (w_instr == I_JAL);
          w_illegal   = (w_instr == I_BAD);
        end
        S_EX: begin
          if (w_instr == I_BEQ) w_pc_write = bus.Equal;
          else w_pc_write = (w_instr == I_JR) || (w_instr == I_JALR);
          w_reg_write = (w_instr == I_JALR);
        end
        S_MEM: w_mem_write = (w_instr == I_SW);
        S_WB:  w_reg_write = 1'b1;
        default: ;
      endcase
    end
  end

  // Next state, plus the retire flag raised in each instruction's final state
  always_comb begin
    w_next   = S_IF;
    w_retire = 1'b0;
    case (r_state)
      S_IF: w_next = S_DT;
      S_DT: begin
        if (w_instr == I_J || w_instr == I_JAL) begin
          w_next   = S_IF;
          w_retire = 1'b1;
        end else if (w_instr == I_BAD) begin
          w_next = S_IF;
        end else begin
          w_next = S_EX;
        end
      end
      S_EX: begin
        if (w_instr == I_LW || w_instr == I_SW) begin
          w_next = S_MEM;
        end else if (w_alu) begin
          w_next = S_WB;
        end else begin
          w_next   = S_IF;
          w_retire = 1'b1;
        end
      end
      S_MEM: begin
        if (!bus.MemReady) begin
          w_next = S_MEM;
        end else if (w_instr == I_LW) begin
          w_next = S_WB;
        end else begin
          w_next   = S_IF;
          w_retire = 1'b1;
        end
      end
      S_WB: begin
        w_next   = S_IF;
        w_retire = 1'b1;
      end
      default: w_next = S_IF;
    endcase
  end

  // State register and retired-instruction counter (wraps naturally)
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state     <= S_IF;
      r_instr_cnt <= 32'd0;
    end else begin
      r_state <= w_next;
      if (w_retire) r_instr_cnt <= r_instr_cnt + 32'd1;
    end
  end

  assign bus.State    = r_state;
  assign bus.InstrCnt = r_instr_cnt;
  assign bus.PCWrite  = w_pc_write;
  assign bus.IRWrite  = w_ir_write;
  assign bus.RegWrite = w_reg_write;
  assign bus.MemWrite = w_mem_write;
  assign bus.Illegal  = w_illegal;
  assign bus.NPCSel   = (r_state == S_IF) ? 2'd0 : w_npc_sel;
  assign bus.RegDst   = w_reg_dst;
  assign bus.ALUsrc   = w_alu_src;
  assign bus.MemtoReg = w_mem_to_reg;
  assign bus.JAL      = w_jal;
  assign bus.JR       = w_jr;
  assign bus.JALR     = w_jalr;
  assign bus.ExtOp    = w_ext_op;
  assign bus.ALUOp    = w_alu_op;

endmodule

// File: tb/tb_mcycle_ctrl.sv
// Directed bench for mcycle_ctrl: walks addu, ori, lw with stalls, beq both
// ways, jal, jr, an illegal opcode and a reset landing in a sw MEM stall.
module tb_mcycle_ctrl;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;
  logic [31:0] exp_q[$];
  logic [31:0] exp_cnt;

  mcycle_ctrl_if bus ();

  mcycle_ctrl dut (
    .Clk   (clk),
    .Reset (reset),
    .bus   (bus)
  );

  // Clock and watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Check one cycle's state and strobes, then move to the next cycle
  task automatic cyc(input string tag, input logic [2:0] st, input logic pcw,
                     input logic irw, input logic rw, input logic mw, input logic ill);
    #1;
    check({tag, ".state"},    32'(bus.State),    32'(st));
    check({tag, ".pcwrite"},  32'(bus.PCWrite),  32'(pcw));
    check({tag, ".irwrite"},  32'(bus.IRWrite),  32'(irw));
    check({tag, ".regwrite"}, 32'(bus.RegWrite), 32'(rw));
    check({tag, ".memwrite"}, 32'(bus.MemWrite), 32'(mw));
    check({tag, ".illegal"},  32'(bus.Illegal),  32'(ill));
    @(negedge clk);
  endtask

  task automatic push_cnt(input logic [31:0] c);
    exp_q.push_back(c);
  endtask

  task automatic check_cnt(input string tag);
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: got empty queue, expected entry", tag);
    end else begin
      e = exp_q.pop_front();
      check(tag, bus.InstrCnt, e);
    end
  endtask

  task automatic set_instr(input logic [5:0] op, input logic [5:0] funct);
    bus.Op    = op;
    bus.Funct = funct;
  endtask

  initial begin
    n_checks     = 0;
    n_errors     = 0;
    exp_cnt      = 32'd0;
    reset        = 1'b1;
    bus.Op       = 6'd0;
    bus.Funct    = 6'd0;
    bus.Equal    = 1'b0;
    bus.MemReady = 1'b0;
    repeat (2) @(negedge clk);

    // Held in reset: IF, count 0, all strobes forced low
    push_cnt(32'd0);
    check_cnt("rst.cnt");
    cyc("rst", 3'd0, 0, 0, 0, 0, 0);
    reset = 1'b0;

    // addu: 0,1,2,4 then IF; RegWrite only in WB
    set_instr(6'h00, 6'h21);
    cyc("addu.if", 3'd0, 1, 1, 0, 0, 0);
    #1 check("addu.regdst", 32'(bus.RegDst), 32'd1);
    cyc("addu.dt", 3'd1, 0, 0, 0, 0, 0);
    cyc("addu.ex", 3'd2, 0, 0, 0, 0, 0);
    cyc("addu.wb", 3'd4, 0, 0, 1, 0, 0);
    exp_cnt = exp_cnt + 1;
    push_cnt(exp_cnt);
    check_cnt("addu.cnt");

    // ori: immediate path, rt destination
    set_instr(6'h0D, 6'h00);
    cyc("ori.if", 3'd0, 1, 1, 0, 0, 0);
    #1;
    check("ori.regdst", 32'(bus.RegDst), 32'd0);
    check("ori.alusrc", 32'(bus.ALUsrc), 32'd1);
    check("ori.aluop",  32'(bus.ALUOp),  32'd2);
    cyc("ori.dt", 3'd1, 0, 0, 0, 0, 0);
    cyc("ori.ex", 3'd2, 0, 0, 0, 0, 0);
    cyc("ori.wb", 3'd4, 0, 0, 1, 0, 0);
    exp_cnt = exp_cnt + 1;
    push_cnt(exp_cnt);
    check_cnt("ori.cnt");

    // lw with three stall cycles: 8 cycles total
    set_instr(6'h23, 6'h00);
    bus.MemReady = 1'b0;
    cyc("lw.if", 3'd0, 1, 1, 0, 0, 0);
    #1;
    check("lw.extop", 32'(bus.ExtOp), 32'd1);
    check("lw.alusrc", 32'(bus.ALUsrc), 32'd1);
    cyc("lw.dt", 3'd1, 0, 0, 0, 0, 0);
    cyc("lw.ex", 3'd2, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc("lw.stall", 3'd3, 0, 0, 0, 0, 0);
    bus.MemReady = 1'b1;
    cyc("lw.mem", 3'd3, 0, 0, 0, 0, 0);
    bus.MemReady = 1'b0;
    #1 check("lw.memtoreg", 32'(bus.MemtoReg), 32'd1);
    cyc("lw.wb", 3'd4, 0, 0, 1, 0, 0);
    exp_cnt = exp_cnt + 1;
    push_cnt(exp_cnt);
    check_cnt("lw.cnt");

    // beq not taken, then taken
    set_instr(6'h04, 6'h00);
    bus.Equal = 1'b0;
    cyc("beq0.if", 3'd0, 1, 1, 0, 0, 0);
    cyc("beq0.dt", 3'd1, 0, 0, 0, 0, 0);
    #1;
    check("beq0.npcsel", 32'(bus.NPCSel), 32'd1);
    check("beq0.aluop",  32'(bus.ALUOp),  32'd1);
    cyc("beq0.ex", 3'd2, 0, 0, 0, 0, 0);
    exp_cnt = exp_cnt + 1;
    push_cnt(exp_cnt);
    check_cnt("beq0.cnt");
    bus.Equal = 1'b1;
    cyc("beq1.if", 3'd0, 1, 1, 0, 0, 0);
    cyc("beq1.dt", 3'd1, 0, 0, 0, 0, 0);
    #1 check("beq1.npcsel", 32'(bus.NPCSel), 32'd1);
    cyc("beq1.ex", 3'd2, 1, 0, 0, 0, 0);
    bus.Equal = 1'b0;
    exp_cnt = exp_cnt + 1;
    push_cnt(exp_cnt);
    check_cnt("beq1.cnt");

    // jal: done in DT
    set_instr(6'h03, 6'h00);
    cyc("jal.if", 3'd0, 1, 1, 0, 0, 0);
    #1;
    check("jal.npcsel", 32'(bus.NPCSel), 32'd2);
    check("jal.jal",    32'(bus.JAL),    32'd1);
    cyc("jal.dt", 3'd1, 1, 0, 1, 0, 0);
    exp_cnt = exp_cnt + 1;
    push_cnt(exp_cnt);
    check_cnt("jal.cnt");

    // jr: register jump in EX
    set_instr(6'h00, 6'h08);
    cyc("jr.if", 3'd0, 1, 1, 0, 0, 0);
    cyc("jr.dt", 3'd1, 0, 0, 0, 0, 0);
    #1;
    check("jr.npcsel", 32'(bus.NPCSel), 32'd3);
    check("jr.jr",     32'(bus.JR),     32'd1);
    cyc("jr.ex", 3'd2, 1, 0, 0, 0, 0);
    exp_cnt = exp_cnt + 1;
    push_cnt(exp_cnt);
    check_cnt("jr.cnt");

    // Unknown opcode: Illegal pulse in DT, back to IF, not retired
    set_instr(6'h3F, 6'h00);
    cyc("ill.if", 3'd0, 1, 1, 0, 0, 0);
    cyc("ill.dt", 3'd1, 0, 0, 0, 0, 1);
    push_cnt(exp_cnt);
    check_cnt("ill.cnt");

    // sw stalled in MEM, then reset lands mid-stall
    set_instr(6'h2B, 6'h00);
    bus.MemReady = 1'b0;
    cyc("sw.if", 3'd0, 1, 1, 0, 0, 0);
    cyc("sw.dt", 3'd1, 0, 0, 0, 0, 0);
    cyc("sw.ex", 3'd2, 0, 0, 0, 0, 0);
    cyc("sw.mem0", 3'd3, 0, 0, 0, 1, 0);
    cyc("sw.mem1", 3'd3, 0, 0, 0, 1, 0);
    reset = 1'b1;
    cyc("sw.rstforce", 3'd3, 0, 0, 0, 0, 0);
    push_cnt(32'd0);
    check_cnt("sw.rstcnt");
    cyc("sw.rstif", 3'd0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    cyc("post.if", 3'd0, 1, 1, 0, 0, 0);
    cyc("post.dt", 3'd1, 0, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
